riscv_pmp_arb: RTL and testbench
================================

Name:
riscv_pmp_arb

Overview:
- Shares one riscv_pmpchk instance between two requesters: instruction fetch (IF) and data memory (DM).
- Grants at most one PMP check per cycle and drives the checker's access inputs from the winner.
- Registers the checker's combinational results into a per-port response one cycle after the grant.
- Blocks grants while PMP CSRs change and for a settle window afterwards, so no check runs against half-updated bounds.

Parameters:
- PLEN, 34, physical address width; matches the checker.
- STARVE_LIMIT, 4, consecutive cycles IF may be denied before it wins a conflict (1..15).
- SETTLE_CYCLES, 2, grant-blocked cycles after the last pmp_upd cycle (1..15).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- pmp_upd  in  1  pmpcfg/pmpaddr CSR write in progress this cycle
- if_req  in  1  IF check request; held until if_gnt
- if_adr  in  PLEN  IF physical address
- if_gnt  out  1  IF granted this cycle (combinational)
- if_rsp_valid  out  1  IF result valid
- if_rsp_exception  out  1  IF access fault
- if_rsp_misaligned  out  1  IF misaligned
- if_rsp_cacheable  out  1  IF cacheable
- dm_req  in  1  DM check request; held until dm_gnt
- dm_adr  in  PLEN  DM physical address
- dm_size  in  biu_size_t  DM transfer size
- dm_we  in  1  DM write
- dm_gnt  out  1  DM granted this cycle (combinational)
- dm_rsp_valid, dm_rsp_exception, dm_rsp_misaligned, dm_rsp_cacheable  out  1 each  DM result, same meaning as IF
- chk_req  out  1  to checker access_req
- chk_instruction  out  1  to checker access_instruction
- chk_adr  out  PLEN  to checker access_adr
- chk_size  out  biu_size_t  to checker access_size
- chk_we  out  1  to checker access_we
- chk_is_exception  in  1  from checker is_access_exception (combinational)
- chk_is_misaligned  in  1  from checker is_misaligned
- chk_is_cacheable  in  1  from checker is_cacheable

Behaviour:
- Reset (async): all gnt/rsp outputs 0, starvation counter 0, state SETTLE with settle counter = SETTLE_CYCLES. The rr pointer resets only when the optional feature is compiled in.
- States:
  - RUN: grants allowed.
  - SETTLE: no grants. Settle counter decrements each cycle; at count 1 with pmp_upd=0, next state is RUN.
- pmp_upd=1 in any state: next state SETTLE, counter reloaded to SETTLE_CYCLES, no grant in that cycle. A pmp_upd pulse during SETTLE reloads the counter.
- Grant in RUN (combinational):
  - Only one requester: it wins.
  - Both requesting: DM wins unless starvation counter == STARVE_LIMIT, in which case IF wins.
  - if_gnt and dm_gnt are never both 1.
- Starvation counter (4 bit):
  - +1 each cycle if_req=1 and if_gnt=0, saturating at STARVE_LIMIT.
  - Cleared on if_gnt or if_req=0.
  - Holds in SETTLE.
- Checker drive:
  - chk_req = if_gnt|dm_gnt.
  - IF granted: chk_instruction=1, chk_adr=if_adr, chk_size=WORD, chk_we=0.
  - Otherwise: chk_instruction=0, chk_adr=dm_adr, chk_size=dm_size, chk_we=dm_we.
- Response, latency 1:
  - On the edge after a grant, the granted port's rsp_valid=1 and its flags load chk_is_*.
  - Ungranted port: rsp_valid=0, flags=0.
  - rsp_valid is a single-cycle pulse per grant. Back-to-back grants give back-to-back pulses.
- Request/grant same cycle: the requester may change adr/size/we in the cycle after gnt.
- Reset mid-operation: a pending response is dropped, rsp outputs go 0 immediately, and SETTLE re-enters.

Optional Feature:
- RV12_PMP_ARB_RR_EN defined:
  - Conflicts resolve by round-robin: a 1-bit pointer toggles on each conflict grant; after reset DM has priority.
  - Starvation counter and STARVE_LIMIT are unused.
- Undefined: DM priority with starvation limit as above.

Test Plan:
- Reset release, if_req=1 held, SETTLE_CYCLES=2 -> if_gnt=0 in cycles 0-1, if_gnt=1 in cycle 2, if_rsp_valid=1 in cycle 3 with chk_instruction=1 and chk_size=WORD in cycle 2.
- if_req and dm_req held, STARVE_LIMIT=4 -> dm_gnt cycles 0-3, if_gnt cycle 4; pattern repeats with period 5; never both grants.
- dm_req, dm_size=WORD, dm_adr=0x2, checker model returns misaligned=1, exception=0, cacheable=1 -> next cycle dm_rsp_valid=1, dm_rsp_misaligned=1, dm_rsp_exception=0, dm_rsp_cacheable=1, if_rsp_valid=0.
- Continuous dm_req, single-cycle pmp_upd in cycle 5 -> dm_gnt=0 in cycles 5-7, dm_gnt=1 from cycle 8. A second pmp_upd in cycle 7 extends the block to cycle 9 inclusive.
- rst asserted asynchronously between a grant and its response edge -> dm_rsp_valid stays 0, no response pulse after rst release, grants blocked for SETTLE_CYCLES.
- RV12_PMP_ARB_RR_EN, both requesting continuously -> grants alternate DM, IF, DM, IF from the first RUN cycle.

Source files
------------

// File: rtl/riscv_pmp_arb_pkg.sv
// Shared types for the PMP checker arbiter: BIU transfer size and registered response payload.
package riscv_pmp_arb_pkg;

    typedef enum logic [2:0] {
        BYTE  = 3'd0,
        HWORD = 3'd1,
        WORD  = 3'd2,
        DWORD = 3'd3,
        QWORD = 3'd4
    } biu_size_t;

    typedef struct packed {
        logic valid;
        logic exception;
        logic misaligned;
        logic cacheable;
    } pmp_rsp_t;

endpackage

// File: rtl/riscv_pmp_arb_if.sv
// Request, grant, response and checker-drive signals of the PMP checker arbiter.
interface riscv_pmp_arb_if
    import riscv_pmp_arb_pkg::*;
#(
    parameter int unsigned PLEN = 34
);

    logic            if_req;
    logic [PLEN-1:0] if_adr;
    logic            if_gnt;
    logic            if_rsp_valid;
    logic            if_rsp_exception;
    logic            if_rsp_misaligned;
    logic            if_rsp_cacheable;

    logic            dm_req;
    logic [PLEN-1:0] dm_adr;
    biu_size_t       dm_size;
    logic            dm_we;
    logic            dm_gnt;
    logic            dm_rsp_valid;
    logic            dm_rsp_exception;
    logic            dm_rsp_misaligned;
    logic            dm_rsp_cacheable;

    logic            chk_req;
    logic            chk_instruction;
    logic [PLEN-1:0] chk_adr;
    biu_size_t       chk_size;
    logic            chk_we;
    logic            chk_is_exception;
    logic            chk_is_misaligned;
    logic            chk_is_cacheable;

    // Arbiter side
    modport slave (
        input  if_req, if_adr, dm_req, dm_adr, dm_size, dm_we,
               chk_is_exception, chk_is_misaligned, chk_is_cacheable,
        output if_gnt, if_rsp_valid, if_rsp_exception, if_rsp_misaligned, if_rsp_cacheable,
               dm_gnt, dm_rsp_valid, dm_rsp_exception, dm_rsp_misaligned, dm_rsp_cacheable,
               chk_req, chk_instruction, chk_adr, chk_size, chk_we
    );

    // Requester / checker side
    modport master (
        output if_req, if_adr, dm_req, dm_adr, dm_size, dm_we,
               chk_is_exception, chk_is_misaligned, chk_is_cacheable,
        input  if_gnt, if_rsp_valid, if_rsp_exception, if_rsp_misaligned, if_rsp_cacheable,
               dm_gnt, dm_rsp_valid, dm_rsp_exception, dm_rsp_misaligned, dm_rsp_cacheable,
               chk_req, chk_instruction, chk_adr, chk_size, chk_we
    );

endinterface

// File: rtl/riscv_pmp_arb.sv
// Shares one PMP checker between instruction fetch and data memory, one check per cycle.
// Optional RV12_PMP_ARB_RR_EN: round-robin conflict resolution instead of DM priority + starvation limit.
module riscv_pmp_arb
    import riscv_pmp_arb_pkg::*;
#(
    parameter int unsigned PLEN          = 34,
    parameter int unsigned STARVE_LIMIT  = 4,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pmp_upd,
    riscv_pmp_arb_if.slave   bus
);

    localparam int unsigned CW = 4;
    localparam logic [CW-1:0] SETTLE_INIT = CW'(SETTLE_CYCLES);

    typedef enum logic {
        ST_SETTLE = 1'b0,
        ST_RUN    = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   settle_q, settle_d;
    logic            grant_ok;
    logic            if_prio;
    logic            if_win;
    logic            dm_win;
    logic [PLEN-1:0] adr_sel;
    pmp_rsp_t        if_rsp_q, dm_rsp_q;
    pmp_rsp_t        chk_rsp;

`ifdef RV12_PMP_ARB_RR_EN
    logic rr_q, rr_d;
`else
    localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);
    logic [CW-1:0] starve_q, starve_d;
`endif

    // Grant decision, settle sequencing and fairness bookkeeping
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        if_win   = 1'b0;
        dm_win   = 1'b0;
        grant_ok = (state_q == ST_RUN) && !pmp_upd;
`ifdef RV12_PMP_ARB_RR_EN
        rr_d     = rr_q;
        if_prio  = rr_q;
`else
        starve_d = starve_q;
        if_prio  = (starve_q == STARVE_MAX);
`endif

        if (grant_ok) begin
            if_win = bus.if_req && (!bus.dm_req || if_prio);
            dm_win = bus.dm_req && !if_win;
        end

        if (pmp_upd) begin
            state_d  = ST_SETTLE;
            settle_d = SETTLE_INIT;
        end else if (state_q == ST_SETTLE) begin
            if (settle_q <= CW'(1)) begin
                state_d = ST_RUN;
            end
            if (settle_q != '0) begin
                settle_d = settle_q - CW'(1);
            end
        end

`ifdef RV12_PMP_ARB_RR_EN
        if (grant_ok && bus.if_req && bus.dm_req) begin
            rr_d = !rr_q;
        end
`else
        // Counter freezes while grants are blocked so SETTLE does not age IF
        if (!bus.if_req || if_win) begin
            starve_d = '0;
        end else if (state_q == ST_RUN && starve_q != STARVE_MAX) begin
            starve_d = starve_q + CW'(1);
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_SETTLE;
            settle_q <= SETTLE_INIT;
`ifdef RV12_PMP_ARB_RR_EN
            rr_q     <= 1'b0;
`else
            starve_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
`ifdef RV12_PMP_ARB_RR_EN
            rr_q     <= rr_d;
`else
            starve_q <= starve_d;
`endif
        end
    end

    assign adr_sel = if_win ? bus.if_adr : bus.dm_adr;

    // Checker access inputs follow the winner; DM fields are the idle default
    always_comb begin
        bus.if_gnt          = if_win;
        bus.dm_gnt          = dm_win;
        bus.chk_req         = if_win | dm_win;
        bus.chk_instruction = if_win;
        bus.chk_adr         = adr_sel;
        bus.chk_size        = bus.dm_size;
        bus.chk_we          = bus.dm_we;
        if (if_win) begin
            bus.chk_size = WORD;
            bus.chk_we   = 1'b0;
        end
    end

    always_comb begin
        chk_rsp            = '0;
        chk_rsp.valid      = 1'b1;
        chk_rsp.exception  = bus.chk_is_exception;
        chk_rsp.misaligned = bus.chk_is_misaligned;
        chk_rsp.cacheable  = bus.chk_is_cacheable;
    end

    // Checker result captured for the granted port only; the other port reads all-zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_rsp_q <= '0;
            dm_rsp_q <= '0;
        end else begin
            if_rsp_q <= if_win ? chk_rsp : '0;
            dm_rsp_q <= dm_win ? chk_rsp : '0;
        end
    end

    assign bus.if_rsp_valid      = if_rsp_q.valid;
    assign bus.if_rsp_exception  = if_rsp_q.exception;
    assign bus.if_rsp_misaligned = if_rsp_q.misaligned;
    assign bus.if_rsp_cacheable  = if_rsp_q.cacheable;
    assign bus.dm_rsp_valid      = dm_rsp_q.valid;
    assign bus.dm_rsp_exception  = dm_rsp_q.exception;
    assign bus.dm_rsp_misaligned = dm_rsp_q.misaligned;
    assign bus.dm_rsp_cacheable  = dm_rsp_q.cacheable;

    a_one_grant: assert property (@(posedge clk) disable iff (rst)
        !(bus.if_gnt && bus.dm_gnt));

    a_no_grant_on_upd: assert property (@(posedge clk) disable iff (rst)
        pmp_upd |-> !(bus.if_gnt || bus.dm_gnt));

endmodule

// File: tb/tb_riscv_pmp_arb.sv
// Self-checking bench for riscv_pmp_arb: reference arbitration model plus response scoreboard.
module tb_riscv_pmp_arb;
    import riscv_pmp_arb_pkg::*;

    localparam int PLEN          = 34;
    localparam int STARVE_LIMIT  = 4;
    localparam int SETTLE_CYCLES = 2;

    typedef struct packed {
        logic       is_if;
        logic [2:0] flags;   // {exception, misaligned, cacheable}
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic pmp_upd;

    riscv_pmp_arb_if #(.PLEN(PLEN)) bus ();

    riscv_pmp_arb #(
        .PLEN         (PLEN),
        .STARVE_LIMIT (STARVE_LIMIT),
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .pmp_upd(pmp_upd),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Stand-in PMP checker: top bit faults, next bit uncacheable, alignment by size
    function automatic logic [2:0] chk_model(input logic [PLEN-1:0] adr, input biu_size_t size);
        logic exc, mis, cac;
        exc = adr[PLEN-1];
        cac = !adr[PLEN-2];
        mis = (size == HWORD && adr[0]) ||
              (size == WORD  && adr[1:0] != 2'b00) ||
              (size == DWORD && adr[2:0] != 3'b000);
        return {exc, mis, cac};
    endfunction

    assign {bus.chk_is_exception, bus.chk_is_misaligned, bus.chk_is_cacheable} =
        chk_model(bus.chk_adr, bus.chk_size);

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    bit m_run;
    int m_settle;
    int m_starve;
    bit m_rr;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run    = 1'b0;
        m_settle = SETTLE_CYCLES;
        m_starve = 0;
        m_rr     = 1'b0;
        sb.delete();
    endtask

    // Compare registered responses against the scoreboard head
    task automatic check_rsp();
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("if_rsp_valid", bus.if_rsp_valid, e.is_if);
            check("dm_rsp_valid", bus.dm_rsp_valid, !e.is_if);
            if (e.is_if) begin
                check("if_rsp_flags", {bus.if_rsp_exception, bus.if_rsp_misaligned, bus.if_rsp_cacheable}, e.flags);
                check("dm_rsp_flags_idle", {bus.dm_rsp_exception, bus.dm_rsp_misaligned, bus.dm_rsp_cacheable}, 3'b000);
            end else begin
                check("dm_rsp_flags", {bus.dm_rsp_exception, bus.dm_rsp_misaligned, bus.dm_rsp_cacheable}, e.flags);
                check("if_rsp_flags_idle", {bus.if_rsp_exception, bus.if_rsp_misaligned, bus.if_rsp_cacheable}, 3'b000);
            end
        end else begin
            check("rsp_idle", {bus.if_rsp_valid, bus.if_rsp_exception, bus.if_rsp_misaligned, bus.if_rsp_cacheable,
                               bus.dm_rsp_valid, bus.dm_rsp_exception, bus.dm_rsp_misaligned, bus.dm_rsp_cacheable}, 8'h00);
        end
    endtask

    // Drive one cycle (entered just after a rising edge), check grants now and responses after the edge
    task automatic cycle(input logic upd, input logic ireq, input logic [PLEN-1:0] iadr,
                         input logic dreq, input logic [PLEN-1:0] dadr, input biu_size_t dsz,
                         input logic dwe, output logic og_if, output logic og_dm);
        bit ok, ifp, eg_if, eg_dm;
        pmp_upd     = upd;
        bus.if_req  = ireq;
        bus.if_adr  = iadr;
        bus.dm_req  = dreq;
        bus.dm_adr  = dadr;
        bus.dm_size = dsz;
        bus.dm_we   = dwe;
        #1;
        ok = m_run && !upd;
`ifdef RV12_PMP_ARB_RR_EN
        ifp = m_rr;
`else
        ifp = (m_starve == STARVE_LIMIT);
`endif
        eg_if = ok && ireq && (!dreq || ifp);
        eg_dm = ok && dreq && !eg_if;
        check("if_gnt", bus.if_gnt, eg_if);
        check("dm_gnt", bus.dm_gnt, eg_dm);
        check("chk_req", bus.chk_req, eg_if || eg_dm);
        if (eg_if) begin
            check("chk_if_fields", {bus.chk_instruction, bus.chk_adr, bus.chk_size, bus.chk_we},
                  {1'b1, iadr, WORD, 1'b0});
            sb.push_back('{is_if: 1'b1, flags: chk_model(iadr, WORD)});
        end else if (eg_dm) begin
            check("chk_dm_fields", {bus.chk_instruction, bus.chk_adr, bus.chk_size, bus.chk_we},
                  {1'b0, dadr, dsz, dwe});
            sb.push_back('{is_if: 1'b0, flags: chk_model(dadr, dsz)});
        end
        og_if = bus.if_gnt;
        og_dm = bus.dm_gnt;
`ifdef RV12_PMP_ARB_RR_EN
        if (ok && ireq && dreq) m_rr = !m_rr;
`else
        if (!ireq || eg_if) m_starve = 0;
        else if (m_run && m_starve < STARVE_LIMIT) m_starve++;
`endif
        if (upd) begin
            m_run    = 1'b0;
            m_settle = SETTLE_CYCLES;
        end else if (!m_run) begin
            if (m_settle <= 1) m_run = 1'b1;
            m_settle--;
        end
        @(posedge clk);
        #1;
        check_rsp();
    endtask

    function automatic logic [PLEN-1:0] rnd_adr();
        return PLEN'({$urandom(), $urandom()});
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic gi, gd, ireq, dreq, upd;
        rst         = 1'b1;
        pmp_upd     = 1'b0;
        bus.if_req  = 1'b1;
        bus.if_adr  = '0;
        bus.dm_req  = 1'b1;
        bus.dm_adr  = '0;
        bus.dm_size = BYTE;
        bus.dm_we   = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_gnt", {bus.if_gnt, bus.dm_gnt, bus.chk_req}, 3'b000);
        check("rst_rsp", {bus.if_rsp_valid, bus.dm_rsp_valid}, 2'b00);
        rst = 1'b0;

        // IF alone out of reset: blocked for the settle window, then granted
        for (int c = 0; c < 4; c++) begin
            cycle(1'b0, c <= 2, PLEN'(34'h0_0000_1004) + PLEN'(c), 1'b0, '0, BYTE, 1'b0, gi, gd);
            if (c <= 2) check("tp1_if_gnt", gi, c == 2);
        end

        // Both requesting continuously
        for (int c = 0; c < 15; c++) begin
            cycle(1'b0, 1'b1, rnd_adr(), 1'b1, rnd_adr(), biu_size_t'(3'($urandom_range(0, 3))),
                  1'($urandom), gi, gd);
`ifdef RV12_PMP_ARB_RR_EN
            check("tp2_dm_gnt", gd, (c % 2) == 0);
`else
            check("tp2_dm_gnt", gd, (c % 5) != 4);
`endif
            check("tp2_excl", gi && gd, 1'b0);
        end

        // Misaligned word access on DM
        cycle(1'b0, 1'b0, '0, 1'b1, PLEN'(34'h2), WORD, 1'b0, gi, gd);
        check("tp3_rsp", {bus.dm_rsp_valid, bus.dm_rsp_misaligned, bus.dm_rsp_exception,
                          bus.dm_rsp_cacheable, bus.if_rsp_valid}, 5'b11010);
        cycle(1'b0, 1'b0, '0, 1'b0, '0, BYTE, 1'b0, gi, gd);

        // Single pmp_upd, then two pulses extending the block
        for (int c = 0; c < 12; c++) begin
            cycle(c == 5, 1'b0, '0, 1'b1, rnd_adr(), BYTE, 1'b1, gi, gd);
            check("tp4a_dm_gnt", gd, !(c >= 5 && c <= 7));
        end
        for (int c = 0; c < 13; c++) begin
            cycle(c == 5 || c == 7, 1'b0, '0, 1'b1, rnd_adr(), HWORD, 1'b0, gi, gd);
            check("tp4b_dm_gnt", gd, !(c >= 5 && c <= 9));
        end

        // Reset between a grant and its response edge
        pmp_upd     = 1'b0;
        bus.dm_req  = 1'b1;
        bus.dm_adr  = PLEN'(34'h1_0000_0040);
        bus.dm_size = WORD;
        #1;
        check("tp5_pre_gnt", bus.dm_gnt, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("tp5_rst_rsp", {bus.dm_rsp_valid, bus.dm_gnt}, 2'b00);
        @(posedge clk);
        #1;
        check("tp5_rst_hold", bus.dm_rsp_valid, 1'b0);
        rst = 1'b0;
        model_reset();
        for (int c = 0; c < 4; c++) begin
            cycle(1'b0, 1'b0, '0, 1'b1, PLEN'(34'h1_0000_0040), WORD, 1'b0, gi, gd);
            check("tp5_dm_gnt", gd, c >= SETTLE_CYCLES);
        end

        // Random traffic with requests held until granted
        ireq = 1'b0;
        dreq = 1'b0;
        for (int c = 0; c < 400; c++) begin
            upd = ($urandom_range(0, 15) == 0);
            cycle(upd, ireq, rnd_adr(), dreq, rnd_adr(), biu_size_t'(3'($urandom_range(0, 4))),
                  1'($urandom), gi, gd);
            check("rnd_excl", gi && gd, 1'b0);
            if (gi || !ireq) ireq = 1'($urandom_range(0, 3) != 0);
            if (gd || !dreq) dreq = 1'($urandom_range(0, 3) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
